vreg_file_mw: RTL and testbench
===============================

# vreg_file_mw

Parametrised dual-read, dual-write vector register file, the successor to the fixed 16×128 vector register file. It adds per-lane write masks, a defined write-collision rule, and a sequenced clear engine that zeroes the array after reset or on request. A compile-time write-to-read bypass is also available. It sits between the vector decode/issue stage (reads) and the vector ALU/load writeback paths (writes).

## Interface
- ADDR_W, 4, register address width; DEPTH = 2**ADDR_W entries
- DATA_W, 128, register width in bits
- LANE_W, 32, lane width; LANES = DATA_W/LANE_W; DATA_W must be a multiple of LANE_W

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr_req  in  1  request a full-array clear
- busy  out  1  clear engine running; writes dropped, read data forced to 0
- clr_done  out  1  one-cycle pulse when a clear finishes
- we_a, we_b  in  1  write enables, ports A/B
- w_addr_a, w_addr_b  in  ADDR_W  write addresses
- w_mask_a, w_mask_b  in  LANES  per-lane write enables; bit i covers bits [i*LANE_W +: LANE_W]
- data_in_a, data_in_b  in  DATA_W  write data
- r_addr_a, r_addr_b  in  ADDR_W  read addresses
- data_out_a, data_out_b  out  DATA_W  read data, combinational from r_addr

## Operation
- Clear FSM states:
  - CLEAR: ptr counts 0..DEPTH-1 and writes row ptr to 0 on each edge. After the edge that clears row DEPTH-1, go to IDLE and pulse clr_done.
  - IDLE: on clr_req=1, load ptr=0 and go to CLEAR.
- Reset behaviour:
  - rst_n=0 forces state=CLEAR, ptr=0, clr_done=0.
  - busy=1 and data_out_a/b=0 immediately.
  - The array itself is not reset; it is zeroed by the CLEAR sweep.
- Normal write (IDLE): for each port with we=1, lane i of row w_addr is written with the data lane iff mask[i]=1. Other lanes are unchanged. A mask of all zeros is a no-op.
- Collision, both ports to the same address in the same cycle:
  - Lanes set only in mask_a take data A.
  - Lanes set in mask_b (alone or also in mask_a) take data B.
  - Port B wins overlapping lanes.
- Writes while busy=1 are dropped silently. The producer must gate on busy.
- clr_req while busy=1 is ignored. The sweep is not restarted.
- clr_req in IDLE together with writes in the same cycle: the writes complete on that edge, and the clear starts on the next edge, so they are zeroed.
- Read: data_out_x = array[r_addr_x] when busy=0, else 0. Reading the same address on both ports is legal.
- Reset mid-clear or mid-write: the sweep restarts from row 0. Any write on the edge that coincides with reset assertion is lost.

## Timing
- Write latency: 1 edge. Data is visible on read ports the cycle after the write edge, or in the same cycle with bypass (see Configuration).
- Read latency: 0 cycles (combinational).
- Clear, if clr_req is sampled at edge t:
  - busy=1 from after edge t.
  - Row k is zeroed at edge t+1+k.
  - busy=0 and clr_done=1 after edge t+DEPTH; clr_done=0 after edge t+DEPTH+1.
  - busy is high for exactly DEPTH cycles.
- After rst_n deasserts: DEPTH rising edges of clearing, then busy=0 with a one-cycle clr_done.
- Reset values: busy=1, clr_done=0, data_out_a=data_out_b=0.

## Configuration
- VREG_BYPASS_EN defined:
  - If busy=0 and r_addr_x matches an active write address, each lane of data_out_x takes the value that lane will hold after the edge. This is the collision-merged write data for masked lanes and the array data otherwise.
  - Forwarding is combinational.
- VREG_BYPASS_EN undefined: data_out_x shows the pre-write array contents during the write cycle.

## Structure
- Package vreg_pkg:
  - lane-count function
  - clear FSM state enum {IDLE, CLEAR}
  - lane-merge function (old, dataA, maskA, dataB, maskB); used by both write and bypass logic
- Sub-module vreg_clr_fsm holds the state, ptr counter, busy and clr_done.
- The top level holds the array, the write merge and the read/bypass mux.

## Test plan
- Reset then release: busy=1, data_out=0 for 16 cycles; clr_done pulses once; then all 16 rows read 0x0.
- Port A writes addr 3, mask 4'b0101, data all 0xFFFFFFFF lanes: addr 3 reads 0x00000000_FFFFFFFF_00000000_FFFFFFFF.
- Collision at addr 7, A mask 4'b1111 with lanes 0xAAAAAAAA, B mask 4'b0011 with lanes 0xBBBBBBBB: reads 0xAAAAAAAA_AAAAAAAA_BBBBBBBB_BBBBBBBB.
- Write addr 5 with clr_req in the same cycle: busy rises the next cycle, and addr 5 reads 0 after clr_done. A write issued while busy leaves its row at 0.
- Mid-clear rst_n pulse at ptr=9: the sweep restarts at row 0; busy lasts 16 further cycles.
- Same-cycle write/read of addr 2: with VREG_BYPASS_EN, data_out shows the new data that cycle; without it, the old data shows, then the new data on the next cycle.

Source files
------------

// File: rtl/vreg_pkg.sv
// Shared types and helpers for the masked dual-write vector register file.
// Optional feature macro used by vreg_file_mw: VREG_BYPASS_EN (write-to-read bypass).
package vreg_pkg;

  // Widest register row the merge helper handles; instances zero-extend into it.
  localparam int unsigned VREG_MAX_W = 1024;

  typedef logic [VREG_MAX_W-1:0] vreg_row_t;

  // Clear engine states.
  typedef enum logic {IDLE, CLEAR} clr_state_e;

  // Number of write-mask lanes in a register of data_w bits.
  function automatic int unsigned lane_count(input int unsigned data_w,
                                             input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

  // Merge two masked writes into an old row. Masks are bit-expanded lane
  // masks (every bit of a lane carries that lane's enable). Port B wins
  // lanes enabled on both ports.
  function automatic vreg_row_t lane_merge(input vreg_row_t old_row,
                                           input vreg_row_t data_a,
                                           input vreg_row_t mask_a,
                                           input vreg_row_t data_b,
                                           input vreg_row_t mask_b);
    return (old_row & ~mask_a & ~mask_b)
         | (data_a  &  mask_a & ~mask_b)
         | (data_b  &  mask_b);
  endfunction

endpackage

// File: rtl/vreg_clr_fsm.sv
// Clear sequencer: sweeps every row to zero after reset or on request,
// holding busy for exactly DEPTH cycles and pulsing clr_done at the end.
module vreg_clr_fsm
  import vreg_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST_ROW = '1;

  clr_state_e state;

  // Sweep state, row pointer and registered status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      ptr      <= '0;
      busy     <= 1'b1;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        CLEAR: begin
          if (ptr == LAST_ROW) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/vreg_file_mw.sv
// Dual-read, dual-write vector register file with per-lane write masks,
// port-B-wins collision merging and a sequenced clear engine.
// Optional: define VREG_BYPASS_EN to forward same-cycle writes to the read ports.
module vreg_file_mw
  import vreg_pkg::*;
#(
  parameter  int ADDR_W = 4,
  parameter  int DATA_W = 128,
  parameter  int LANE_W = 32,
  localparam int LANES  = lane_count(DATA_W, LANE_W),
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] w_addr_a,
  input  logic [ADDR_W-1:0] w_addr_b,
  input  logic [LANES-1:0]  w_mask_a,
  input  logic [LANES-1:0]  w_mask_b,
  input  logic [DATA_W-1:0] data_in_a,
  input  logic [DATA_W-1:0] data_in_b,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] bits_a, bits_b;
  logic              same_row;
  logic [DATA_W-1:0] wr_row_a, wr_row_b;
  logic [DATA_W-1:0] rd_row_a, rd_row_b;

  function automatic vreg_row_t ext(input logic [DATA_W-1:0] v);
    return vreg_row_t'(v);
  endfunction

  vreg_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .ptr      (clr_ptr)
  );

  // Expand lane masks to bit masks for the merge helper.
  for (genvar i = 0; i < LANES; i++) begin : g_mask
    assign bits_a[i*LANE_W +: LANE_W] = {LANE_W{w_mask_a[i]}};
    assign bits_b[i*LANE_W +: LANE_W] = {LANE_W{w_mask_b[i]}};
  end

  // Post-edge contents of each written row, merging both ports on a collision.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    same_row = we_a && we_b && (w_addr_a == w_addr_b);
    wr_row_a = DATA_W'(lane_merge(ext(mem[w_addr_a]), ext(data_in_a), ext(bits_a),
                                  ext(data_in_b), ext(same_row ? bits_b : '0)));
    wr_row_b = DATA_W'(lane_merge(ext(mem[w_addr_b]), ext(data_in_a),
                                  ext(same_row ? bits_a : '0),
                                  ext(data_in_b), ext(bits_b)));
  end

  // Array update: the clear sweep owns the array while busy, else masked writes.
  // NOTE: the array has no reset; the clear sweep zeroes it row by row, which
  // keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_ptr] <= '0;
    end else begin
      if (we_a) mem[w_addr_a] <= wr_row_a;
      if (we_b) mem[w_addr_b] <= wr_row_b;
    end
  end

`ifdef VREG_BYPASS_EN
  logic hit_aa, hit_ba, hit_ab, hit_bb;

  // Read rows with same-cycle writes forwarded lane by lane.
  always_comb begin
    hit_aa   = we_a && (w_addr_a == r_addr_a);
    hit_ba   = we_b && (w_addr_b == r_addr_a);
    hit_ab   = we_a && (w_addr_a == r_addr_b);
    hit_bb   = we_b && (w_addr_b == r_addr_b);
    rd_row_a = DATA_W'(lane_merge(ext(mem[r_addr_a]),
                                  ext(data_in_a), ext(hit_aa ? bits_a : '0),
                                  ext(data_in_b), ext(hit_ba ? bits_b : '0)));
    rd_row_b = DATA_W'(lane_merge(ext(mem[r_addr_b]),
                                  ext(data_in_a), ext(hit_ab ? bits_a : '0),
                                  ext(data_in_b), ext(hit_bb ? bits_b : '0)));
  end
`else
  // Read rows straight from the array (pre-write contents during a write).
  always_comb begin
    rd_row_a = mem[r_addr_a];
    rd_row_b = mem[r_addr_b];
  end
`endif

  assign data_out_a = busy ? '0 : rd_row_a;
  assign data_out_b = busy ? '0 : rd_row_b;

endmodule

// File: tb/tb_vreg_file_mw.sv
// Self-checking bench for vreg_file_mw: directed scenarios plus randomized
// traffic compared every cycle against a lane-level behavioural model.
module tb_vreg_file_mw;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 128;
  localparam int LANE_W = 32;
  localparam int LANES  = DATA_W / LANE_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr_req = 1'b0;
  logic              busy, clr_done;
  logic              we_a = 1'b0, we_b = 1'b0;
  logic [ADDR_W-1:0] w_addr_a = '0, w_addr_b = '0;
  logic [LANES-1:0]  w_mask_a = '0, w_mask_b = '0;
  logic [DATA_W-1:0] data_in_a = '0, data_in_b = '0;
  logic [ADDR_W-1:0] r_addr_a = '0, r_addr_b = '0;
  logic [DATA_W-1:0] data_out_a, data_out_b;

  always #5 clk = ~clk;

  vreg_file_mw #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .we_a(we_a), .we_b(we_b), .w_addr_a(w_addr_a), .w_addr_b(w_addr_b),
    .w_mask_a(w_mask_a), .w_mask_b(w_mask_b), .data_in_a(data_in_a), .data_in_b(data_in_b),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .data_out_a(data_out_a), .data_out_b(data_out_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: register contents plus clear progress.
  logic [DATA_W-1:0] mdl [DEPTH];
  bit                m_busy = 1'b1;
  int                m_rows_cleared = 0;
  bit                m_done = 1'b0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Row value after the currently driven writes land: A first, then B on top.
  function automatic logic [DATA_W-1:0] after_write(input int addr);
    logic [DATA_W-1:0] row;
    row = mdl[addr];
    for (int i = 0; i < LANES; i++)
      if (we_a && int'(w_addr_a) == addr && w_mask_a[i])
        row[i*LANE_W +: LANE_W] = data_in_a[i*LANE_W +: LANE_W];
    for (int i = 0; i < LANES; i++)
      if (we_b && int'(w_addr_b) == addr && w_mask_b[i])
        row[i*LANE_W +: LANE_W] = data_in_b[i*LANE_W +: LANE_W];
    return row;
  endfunction

  function automatic logic [DATA_W-1:0] exp_read(input int addr);
    if (m_busy) return '0;
`ifdef VREG_BYPASS_EN
    return after_write(addr);
`else
    return mdl[addr];
`endif
  endfunction

  task automatic model_reset();
    m_busy = 1'b1;
    m_rows_cleared = 0;
    m_done = 1'b0;
  endtask

  // Advance the model across one rising edge with rst_n high.
  task automatic model_edge();
    logic [DATA_W-1:0] ra, rb;
    bit done_now;
    done_now = 1'b0;
    if (m_busy) begin
      mdl[m_rows_cleared] = '0;
      m_rows_cleared++;
      if (m_rows_cleared == DEPTH) begin
        m_busy = 1'b0;
        done_now = 1'b1;
      end
    end else begin
      ra = after_write(int'(w_addr_a));
      rb = after_write(int'(w_addr_b));
      mdl[w_addr_a] = ra;
      mdl[w_addr_b] = rb;
      if (clr_req) begin
        m_busy = 1'b1;
        m_rows_cleared = 0;
      end
    end
    m_done = done_now;
  endtask

  // One clock: check outputs mid-cycle, cross the edge, return at the negedge.
  task automatic cycle(input string tag);
    #1;
    check({tag, "/busy"}, busy, m_busy);
    check({tag, "/clr_done"}, clr_done, m_done);
    check({tag, "/rd_a"}, data_out_a, exp_read(int'(r_addr_a)));
    check({tag, "/rd_b"}, data_out_b, exp_read(int'(r_addr_b)));
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic quiet();
    we_a = 1'b0; we_b = 1'b0; clr_req = 1'b0;
    w_mask_a = '0; w_mask_b = '0;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [DATA_W-1:0] old_v, new_v;
  int busy_cycles;

  initial begin
    for (int r = 0; r < DEPTH; r++) mdl[r] = 'x;
    model_reset();
    @(negedge clk);
    repeat (2) cycle("reset");
    rst_n = 1'b1;

    // Post-reset sweep and the single clr_done pulse.
    for (int c = 0; c < DEPTH + 2; c++) begin
      r_addr_a = ADDR_W'($urandom); r_addr_b = ADDR_W'($urandom);
      cycle("sweep");
    end
    for (int r = 0; r < DEPTH; r++) begin
      r_addr_a = ADDR_W'(r); r_addr_b = ADDR_W'(DEPTH - 1 - r);
      #1 check("zero_row", data_out_a, '0);
      cycle("zero_scan");
    end

    // Partial-mask write on port A.
    we_a = 1'b1; w_addr_a = 4'd3; w_mask_a = 4'b0101; data_in_a = '1;
    cycle("mask_wr");
    quiet(); r_addr_a = 4'd3;
    #1 check("mask_row3", data_out_a, 128'h00000000_FFFFFFFF_00000000_FFFFFFFF);
    cycle("mask_rd");

    // Collision: port B wins its lanes.
    we_a = 1'b1; w_addr_a = 4'd7; w_mask_a = 4'b1111; data_in_a = {4{32'hAAAAAAAA}};
    we_b = 1'b1; w_addr_b = 4'd7; w_mask_b = 4'b0011; data_in_b = {4{32'hBBBBBBBB}};
    cycle("coll_wr");
    quiet(); r_addr_b = 4'd7;
    #1 check("coll_row7", data_out_b, 128'hAAAAAAAA_AAAAAAAA_BBBBBBBB_BBBBBBBB);
    cycle("coll_rd");

    // Write with clr_req in the same cycle, then a write while busy.
    we_a = 1'b1; w_addr_a = 4'd5; w_mask_a = '1; data_in_a = rand_data(); clr_req = 1'b1;
    cycle("wr_clr");
    quiet();
    #1 check("busy_after_req", busy, 1'b1);
    we_b = 1'b1; w_addr_b = 4'd9; w_mask_b = '1; data_in_b = rand_data(); clr_req = 1'b1;
    cycle("wr_busy");
    quiet();
    for (int c = 0; c < DEPTH; c++) cycle("clr_run");
    r_addr_a = 4'd5; r_addr_b = 4'd9;
    #1 check("row5_cleared", data_out_a, '0);
    check("row9_dropped", data_out_b, '0);
    cycle("clr_check");

    // Reset pulse in the middle of a sweep.
    clr_req = 1'b1;
    cycle("clr2_req");
    quiet();
    for (int c = 0; c < 9; c++) cycle("clr2_run");
    rst_n = 1'b0;
    model_reset();
    cycle("mid_rst");
    rst_n = 1'b1;
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      #1 if (busy) busy_cycles++;
      cycle("post_rst");
    end
    check("busy_len", busy_cycles, 16);

    // Same-cycle write and read of addr 2.
    old_v = rand_data(); new_v = rand_data();
    we_a = 1'b1; w_addr_a = 4'd2; w_mask_a = '1; data_in_a = old_v;
    cycle("byp_pre");
    data_in_a = new_v; r_addr_a = 4'd2;
`ifdef VREG_BYPASS_EN
    #1 check("byp_same", data_out_a, new_v);
`else
    #1 check("byp_same", data_out_a, old_v);
`endif
    cycle("byp_wr");
    quiet();
    #1 check("byp_next", data_out_a, new_v);
    cycle("byp_rd");

    // Randomized traffic, including collisions, clears and writes while busy.
    for (int c = 0; c < 3000; c++) begin
      we_a      = $urandom_range(0, 1) == 1;
      we_b      = $urandom_range(0, 1) == 1;
      w_addr_a  = ADDR_W'($urandom_range(0, 5));
      w_addr_b  = ADDR_W'($urandom_range(0, 5));
      w_mask_a  = LANES'($urandom);
      w_mask_b  = LANES'($urandom);
      data_in_a = rand_data();
      data_in_b = rand_data();
      r_addr_a  = ADDR_W'($urandom_range(0, 7));
      r_addr_b  = ADDR_W'($urandom_range(0, 7));
      clr_req   = $urandom_range(0, 59) == 0;
      cycle("rand");
    end
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
